// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
//
// Architectural register file for the MIPS datapath with a pending-write
// scoreboard. Decode reads two operands combinationally and tags the
// destination of each issued instruction as busy. Write-back writes one
// register per cycle and clears its busy bit. A write-back is forwarded to the
// read ports in the same cycle, so decode never sees stale data.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rs_addr / rs_data    read port A (combinational, write-back bypass)
//   rt_addr / rt_data    read port B (combinational, write-back bypass)
//   issue_valid/_dir     destination tagged busy at the next edge
//   wb_valid/_dir/_data  write-back port, always accepted
//   rs_busy / rt_busy    operand has an in-flight producer
//   pending_cnt          number of busy registers (registered)
//
// Optional build macro REGFILE_DBG_EN adds:
//   dbg_addr / dbg_data  third read port, raw array contents, no bypass
//   wr_count             saturating count of effective register writes
// -----------------------------------------------------------------------------
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dir,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dir,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   pending_cnt
`ifdef REGFILE_DBG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
`endif
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pending_cnt_q, pending_cnt_d;

  logic wr_en;
  logic issue_en;

  // Register 0 absorbs writes and issues when it is hardwired to zero.
  assign wr_en    = wb_valid    && !(ZERO_REG && (wb_dir    == '0));
  assign issue_en = issue_valid && !(ZERO_REG && (issue_dir == '0));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a full default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_dir] = wb_data;
  end

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set: a new producer issued in the same cycle as the
    // old one retires must stay pending.
    if (wb_valid) busy_d[wb_dir]    = 1'b0;
    if (issue_en) busy_d[issue_dir] = 1'b1;
  end

  // Count is derived from the next busy vector, so it can never drift from
  // the bits or underflow on a write-back to an idle register.
  always_comb begin
    pending_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_cnt_d = pending_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering. The array is reset
  // too, because architectural state must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q        <= '{default: '0};
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: zero register, then same-cycle write-back, then array.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (ZERO_REG && (rs_addr == '0))         rs_data = '0;
    else if (wb_valid && (wb_dir == rs_addr)) rs_data = wb_data;
    else                                      rs_data = regs_q[rs_addr];

    if (ZERO_REG && (rt_addr == '0))         rt_data = '0;
    else if (wb_valid && (wb_dir == rt_addr)) rt_data = wb_data;
    else                                      rt_data = regs_q[rt_addr];
  end

  // A producer writing back this cycle is already covered by the bypass.
  assign rs_busy     = busy_q[rs_addr] & ~(wb_valid && (wb_dir == rs_addr));
  assign rt_busy     = busy_q[rt_addr] & ~(wb_valid && (wb_dir == rt_addr));
  assign pending_cnt = pending_cnt_q;

`ifdef REGFILE_DBG_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign dbg_data = regs_q[dbg_addr];
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wb
//
// Directed bench for reg_file_wb: reset state, bypass, zero register,
// scoreboard set/clear/collision, write-back to idle register and
// asynchronous reset in mid-cycle. Inputs change 1 time unit after the rising
// edge; outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_reg_file_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dir;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dir;
  logic [DATA_W-1:0] wb_data;
  logic              rs_busy, rt_busy;
  logic [ADDR_W:0]   pending_cnt;
`ifdef REGFILE_DBG_EN
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .issue_valid (issue_valid),
    .issue_dir   (issue_dir),
    .wb_valid    (wb_valid),
    .wb_dir      (wb_dir),
    .wb_data     (wb_data),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .pending_cnt (pending_cnt)
`ifdef REGFILE_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .wr_count    (wr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_dir   = '0;
    wb_valid    = 1'b0;
    wb_dir      = '0;
    wb_data     = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
`ifdef REGFILE_DBG_EN
    dbg_addr = '0;
`endif
    idle_inputs();
    #22;
    rst_n = 1'b1;
    tick();

    // --- Reset state on every address ---------------------------------------
    for (int i = 0; i < 32; i++) begin
      rs_addr = ADDR_W'(i);
      rt_addr = ADDR_W'(31 - i);
      #1;
      check($sformatf("rst_rs_data[%0d]", i), rs_data, 32'h0);
      check($sformatf("rst_rt_data[%0d]", 31 - i), rt_data, 32'h0);
      check($sformatf("rst_busy[%0d]", i), {30'b0, rs_busy, rt_busy}, 32'h0);
    end
    check("rst_pending", 32'(pending_cnt), 32'd0);

    // --- Same-cycle bypass, then array read ---------------------------------
    wb_valid = 1'b1; wb_dir = 5'd5; wb_data = 32'hDEADBEEF;
    rs_addr  = 5'd5; rt_addr = 5'd6;
    #1;
    check("bypass_rs", rs_data, 32'hDEADBEEF);
    check("bypass_rt_other", rt_data, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("after_wb_rs", rs_data, 32'hDEADBEEF);
`ifdef REGFILE_DBG_EN
    dbg_addr = 5'd5;
    #1;
    check("dbg_reg5", dbg_data, 32'hDEADBEEF);
    check("wr_count_1", 32'(wr_count), 32'd1);
`endif

    // --- Zero register: write and issue are no-ops --------------------------
    wb_valid = 1'b1; wb_dir = 5'd0; wb_data = 32'h12345678;
    issue_valid = 1'b1; issue_dir = 5'd0;
    rs_addr = 5'd0;
    #1;
    check("zero_rs_bypass", rs_data, 32'h0);
    check("zero_rs_busy_same", 32'(rs_busy), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("zero_rs_data", rs_data, 32'h0);
    check("zero_rs_busy", 32'(rs_busy), 32'd0);
    check("zero_pending", 32'(pending_cnt), 32'd0);

    // --- Issue 7, then write back 7 -----------------------------------------
    issue_valid = 1'b1; issue_dir = 5'd7;
    tick();
    idle_inputs();
    rt_addr = 5'd7;
    #1;
    check("iss7_rt_busy", 32'(rt_busy), 32'd1);
    check("iss7_pending", 32'(pending_cnt), 32'd1);
    tick();
    wb_valid = 1'b1; wb_dir = 5'd7; wb_data = 32'h0000A5A5;
    #1;
    check("wb7_rt_busy_same", 32'(rt_busy), 32'd0);
    check("wb7_rt_data_same", rt_data, 32'h0000A5A5);
    check("wb7_pending_same", 32'(pending_cnt), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("wb7_pending_after", 32'(pending_cnt), 32'd0);
    check("wb7_rt_busy_after", 32'(rt_busy), 32'd0);
    check("wb7_rt_data_after", rt_data, 32'h0000A5A5);

    // --- Collision on busy register 9: set wins ------------------------------
    issue_valid = 1'b1; issue_dir = 5'd9;
    tick();
    idle_inputs();
    rs_addr = 5'd9;
    #1;
    check("iss9_busy", 32'(rs_busy), 32'd1);
    check("iss9_pending", 32'(pending_cnt), 32'd1);
    issue_valid = 1'b1; issue_dir = 5'd9;
    wb_valid = 1'b1; wb_dir = 5'd9; wb_data = 32'h00000099;
    #1;
    check("col9_busy_masked", 32'(rs_busy), 32'd0);
    check("col9_data_bypass", rs_data, 32'h00000099);
    tick();
    idle_inputs();
    #1;
    check("col9_busy_after", 32'(rs_busy), 32'd1);
    check("col9_pending", 32'(pending_cnt), 32'd1);
    check("col9_data_after", rs_data, 32'h00000099);

    // Re-issue to busy 9: count unchanged. Then issue 10: count 2.
    issue_valid = 1'b1; issue_dir = 5'd9;
    tick();
    #1;
    check("reiss9_pending", 32'(pending_cnt), 32'd1);
    issue_dir = 5'd10;
    tick();
    idle_inputs();
    #1;
    check("iss10_pending", 32'(pending_cnt), 32'd2);

    // Write-back to idle register 12: data written, no underflow.
    wb_valid = 1'b1; wb_dir = 5'd12; wb_data = 32'hCAFEF00D;
    tick();
    idle_inputs();
    rt_addr = 5'd12;
    #1;
    check("wb12_data", rt_data, 32'hCAFEF00D);
    check("wb12_busy", 32'(rt_busy), 32'd0);
    check("wb12_pending", 32'(pending_cnt), 32'd2);

    wb_valid = 1'b1; wb_dir = 5'd9; wb_data = 32'h1;
    tick();
    #1;
    check("clr9_pending", 32'(pending_cnt), 32'd1);
    wb_dir = 5'd10; wb_data = 32'h2;
    tick();
    idle_inputs();
    #1;
    check("clr10_pending", 32'(pending_cnt), 32'd0);

    // --- Asynchronous reset mid-cycle ---------------------------------------
    issue_valid = 1'b1; issue_dir = 5'd3;
    tick();
    idle_inputs();
    wb_valid = 1'b1; wb_dir = 5'd4; wb_data = 32'h44;
    tick();
    wb_dir = 5'd5; wb_data = 32'h55;
    tick();
    idle_inputs();
    rs_addr = 5'd3; rt_addr = 5'd4;
    #1;
    check("pre_rst_busy3", 32'(rs_busy), 32'd1);
    check("pre_rst_pending", 32'(pending_cnt), 32'd1);
    check("pre_rst_reg4", rt_data, 32'h44);
    // In-flight issue/write-back held across the reset must be discarded.
    issue_valid = 1'b1; issue_dir = 5'd8;
    wb_valid    = 1'b1; wb_dir    = 5'd20; wb_data = 32'h77;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy3", 32'(rs_busy), 32'd0);
    check("rst_pending_mid", 32'(pending_cnt), 32'd0);
    check("rst_reg4", rt_data, 32'h0);
    rt_addr = 5'd5;
    #1;
    check("rst_reg5", rt_data, 32'h0);
`ifdef REGFILE_DBG_EN
    dbg_addr = 5'd3;
    #1;
    check("rst_dbg3", dbg_data, 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
`endif
    tick();
    check("rst_hold_pending", 32'(pending_cnt), 32'd0);
    idle_inputs();
    rs_addr = 5'd20; rt_addr = 5'd8;
    #1;
    check("rst_hold_reg20", rs_data, 32'h0);
    check("rst_hold_busy8", 32'(rt_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    #1;
    check("post_rst_pending", 32'(pending_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file of the MIPS datapath, with a pending-write scoreboard.
- It is the consumer of the 5-bit destination address chosen between rt and rd.
- Sits between decode (two read ports, issue tagging) and write-back (one write port).
- Provides write-through bypass so decode sees same-cycle write-back data, and busy flags so the hazard unit can stall on in-flight producers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- issue_valid  input  1  an instruction with a register destination leaves decode this cycle.
- issue_dir  input  ADDR_W  its destination register.
- wb_valid  input  1  write-back this cycle.
- wb_dir  input  ADDR_W  write-back destination register.
- wb_data  input  DATA_W  write-back data.
- rs_busy  output  1  rs_addr has a pending write not yet written back.
- rt_busy  output  1  rt_addr has a pending write not yet written back.
- pending_cnt  output  ADDR_W+1  number of registers currently marked busy.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, immediate, independent of clk):
  - All NREGS registers cleared to 0.
  - All busy bits cleared; pending_cnt=0.
  - Outputs therefore read 0 / not busy.
  - Reset mid-operation discards any in-flight issue or write-back; no partial update.
- Write:
  - On rising clk with wb_valid=1 and not (ZERO_REG and wb_dir==0), regs[wb_dir] <= wb_data.
  - wb_valid=1 with wb_dir==0 (ZERO_REG=1) is a legal no-op.
- Read, 0-cycle latency:
  - rs_data = 0 if ZERO_REG and rs_addr==0.
  - Otherwise wb_data if wb_valid and wb_dir==rs_addr (bypass).
  - Otherwise regs[rs_addr].
  - rt_data is identical with rt_addr.
- Scoreboard, one busy bit per register:
  - Set on clk when issue_valid=1 and issue_dir is not the zero register.
  - Cleared on clk when wb_valid=1 and wb_dir matches.
  - Simultaneous set and clear on the same register: set wins; the newer producer stays pending.
  - Issue to an already-busy register leaves it busy; count is unchanged.
  - Write-back to a non-busy register still writes data; busy stays 0 and the count does not underflow.
- Busy outputs:
  - rs_busy = busy[rs_addr] & ~(wb_valid & wb_dir==rs_addr); the bypass covers the same-cycle write-back. rt_busy is identical with rt_addr.
  - Register 0 is never busy when ZERO_REG=1.
- pending_cnt:
  - Registered popcount of busy bits, updated in the same edge as the bits.
  - Range 0..NREGS-1 with ZERO_REG=1, 0..NREGS otherwise; no wrap.
- No handshake back-pressure: write-back is always accepted; stalling decisions belong to the hazard unit.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- When defined, add ports:
  - dbg_addr  input  ADDR_W: third combinational read port, no bypass.
  - dbg_data  output  DATA_W.
  - wr_count  output  16: counts accepted non-zero-register writes.
- wr_count resets to 0, increments once per effective write and saturates at 16'hFFFF.
- When undefined, these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then read all 32 addresses on rs/rt -> all data 0, rs_busy=rt_busy=0, pending_cnt=0.
- wb_valid=1, wb_dir=5, wb_data=32'hDEADBEEF with rs_addr=5 in the same cycle -> rs_data=DEADBEEF combinationally (bypass); next cycle with wb_valid=0 -> still DEADBEEF.
- wb_valid=1, wb_dir=0, wb_data=32'h12345678; issue_valid=1, issue_dir=0 -> rs_addr=0 reads 0, rs_busy=0, pending_cnt=0.
- Issue dir=7 at cycle 1 -> at cycle 2 rt_addr=7 gives rt_busy=1, pending_cnt=1. Write-back dir=7 at cycle 4 -> rt_busy=0 during cycle 4, pending_cnt=0 after the edge.
- Same cycle issue_dir=9 and wb_dir=9 (reg 9 already busy) -> reg 9 written, busy remains 1, pending_cnt unchanged.
- Issue dir=3, write two registers, assert rst_n=0 mid-cycle -> all outputs 0 immediately. With REGFILE_DBG_EN: dbg_addr=3 -> dbg_data=0, wr_count=0.
